multi_seq_mul: RTL
==================

Name: multi_seq_mul

Overview:
Parametrised iterative unsigned multiplier with a start/busy/done handshake.
- Multiplies WIDTH-bit operands by retiring BITS_PER_CYCLE multiplier bits per clock.
- Holds the 2*WIDTH-bit product on out until the next completed operation.
- Sits behind a transaction-level controller. Latency is fixed, or data-dependent when the optional feature is compiled in.
- Supports abort of an in-flight operation.

Parameters:
WIDTH, 32, operand width in bits (>= 2).
BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; must divide WIDTH; 1, 2, 4 or 8.

Ports:
clock  input  1  clock; all state updates on posedge
reset  input  1  reset, synchronous, active-high
start  input  1  request new operation; sampled only when not busy
cancel  input  1  abort in-flight operation
a  input  WIDTH  multiplicand, sampled with accepted start
b  input  WIDTH  multiplier, sampled with accepted start
busy  output  1  high while an operation is in flight (RUN state)
done  output  1  single-cycle pulse; out carries the new product in this cycle
out  output  2*WIDTH  last completed product

Behaviour:
- N = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE: after reset.
  - RUN: busy=1.
  - DONE: one cycle, done=1, busy=0.
- Reset (any state, including mid-RUN):
  - state=IDLE; busy=0, done=0, out=0.
  - Internal operand, accumulator and counter registers cleared.
- Accept rule:
  - start is accepted in IDLE or DONE.
  - start is ignored in RUN; operands and progress are unaffected.
- On accept at edge ending cycle c:
  - Capture a, b; clear accumulator; iteration counter=0; enter RUN.
- Each RUN edge:
  - chunk = low BITS_PER_CYCLE bits of shifted multiplier.
  - acc += (a * chunk) << (counter*BITS_PER_CYCLE).
  - Multiplier shifts right by BITS_PER_CYCLE; counter += 1.
- After the N-th RUN edge:
  - Enter DONE; out <= final acc.
  - Modulo-free: the 2*WIDTH-bit result never overflows.
- Fixed latency: start accepted in cycle c gives busy high in cycles c+1..c+N and done=1 in cycle c+N+1.
- out is updated only on the edge entering DONE. It is unchanged by start, cancel, or ignored starts.
- DONE with no start: next state IDLE.
- DONE with start: accept in the same cycle, so back-to-back throughput is one result per N+1 cycles.
- cancel in RUN:
  - Next state IDLE; no done pulse; out unchanged.
  - If start is also high in that cycle, it is ignored because busy=1.
- cancel in IDLE or DONE: no effect; start takes effect normally.
- reset has priority over cancel and start.
- Arithmetic is unsigned. Internal accumulator is 2*WIDTH bits; partial product is WIDTH+BITS_PER_CYCLE bits.
- Counter width: clog2(N)+1 bits; no wrap possible within an operation.

Optional Feature:
Macro: MULTI_SEQ_MUL_EARLY_TERM_EN. Early termination.
- Defined:
  - At the end of any RUN edge where the remaining shifted multiplier is zero, enter DONE instead of continuing.
  - Latency = 1 + max(1, ceil((msb_index(b)+1)/BITS_PER_CYCLE)).
  - b=0 gives done in cycle c+2 with out=0.
  - Products are identical to fixed mode; only timing differs.
- Undefined: fixed latency N+1 for every operand.

Test Plan:
1. WIDTH=32, BPC=1: reset; start in cycle 0 with a=3, b=5 -> busy cycles 1..32, done=1 only in cycle 33, out=15, out=0 before cycle 33.
2. a=b=0xFFFFFFFF -> out=0xFFFFFFFE00000001 at done. Repeat with BPC=4 -> same value, done in cycle 9.
3. Operation running a=7, b=9; pulse start with a=1, b=1 in cycle 10 -> ignored; out=63 at cycle 33. Then start in the done cycle with a=2, b=4 -> no IDLE gap, done at cycle 66, out=8.
4. cancel in cycle 15 of an operation a=10, b=10 after a prior result 63 -> busy low at cycle 16, no done, out stays 63. Reset asserted at cycle 5 of a new operation -> out=0, busy=0, done never pulses.
5. With MULTI_SEQ_MUL_EARLY_TERM_EN, BPC=1: start cycle 0, a=6, b=5 -> done cycle 4, out=30. b=0 -> done cycle 2, out=0. b=0x80000000 -> done cycle 33. Without the macro, all three cases give done at cycle 33.

Source files
------------

// File: rtl/multi_seq_mul.sv
// Iterative unsigned multiplier retiring BITS_PER_CYCLE multiplier bits per clock, with start/busy/done handshake.
// Optional early termination on an exhausted multiplier: define MULTI_SEQ_MUL_EARLY_TERM_EN.
module multi_seq_mul #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cancel,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned PW = WIDTH + BITS_PER_CYCLE;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_next;
  logic [WIDTH-1:0]          mcand, mcand_next;
  logic [WIDTH-1:0]          mplier, mplier_next, mplier_shift;
  logic [AW-1:0]             acc, acc_next, acc_sum, out_next;
  logic [CW-1:0]             cnt, cnt_next;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [PW-1:0]             pp;
  logic                      last;

  // One partial-product step: weight the current chunk by its position and accumulate.
  always_comb begin
    chunk        = mplier[BITS_PER_CYCLE-1:0];
    mplier_shift = mplier >> BITS_PER_CYCLE;
    pp           = PW'(mcand) * PW'(chunk);
    acc_sum      = acc + (AW'(pp) << (cnt * BITS_PER_CYCLE));
`ifdef MULTI_SEQ_MUL_EARLY_TERM_EN
    last         = (mplier_shift == '0) || (cnt == CW'(N - 1));
`else
    last         = (cnt == CW'(N - 1));
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_next  = state;
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    cnt_next    = cnt;
    out_next    = out;
    unique case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          state_next  = RUN;
          mcand_next  = a;
          mplier_next = b;
          acc_next    = '0;
          cnt_next    = '0;
        end
      end
      RUN: begin
        if (cancel) begin
          state_next = IDLE;
        end else begin
          acc_next    = acc_sum;
          mplier_next = mplier_shift;
          cnt_next    = cnt + CW'(1);
          if (last) begin
            state_next = DONE;
            out_next   = acc_sum;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; busy/done are registered copies of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      cnt    <= cnt_next;
      out    <= out_next;
      busy   <= (state_next == RUN);
      done   <= (state_next == DONE);
    end
  end

endmodule
